// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter
// Round-robin arbiter that shares one 4:1 single-bit mux between four
// requesters. A grant is held while its requester keeps asking, up to
// MAX_HOLD cycles, then force-released. Every release is followed by at
// least one idle cycle. All outputs are registered.
// MAX_HOLD must lie in 1..255 and 2**CNT_W must exceed MAX_HOLD.
module mux_4x1_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       y_q,
  output logic       y_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Hold counter value on the last permitted grant cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Binary index to one-hot grant vector.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  logic [0:0]       state_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [1:0]       last_r;
  logic [1:0]       sel_r;
  logic [3:0]       gnt_r;
  logic             busy_r;
  logic             y_q_r;
  logic             y_valid_r;
  logic             timeout_r;

  logic             pick_valid_s;
  logic [1:0]       pick_idx_s;
  logic [1:0]       cand_s;
  logic             vol_s;
  logic             lim_s;

  // Rotating priority scan: last+1, last+2, last+3, then last itself.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = last_r;
    cand_s       = last_r;
    for (int k = 1; k <= 4; k++) begin
      cand_s = last_r + 2'(k);
      if (!pick_valid_s && req[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_idx_s   = pick_idx_s;
      end
    end
  end

  // Release conditions for the current owner (sel_r holds the owner index).
  always_comb begin
    vol_s = ~req[sel_r];
    lim_s = (hold_cnt_r == HOLD_LAST);
  end

  // Arbitration FSM with registered outputs and datapath capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= '0;
      last_r     <= 2'd3;
      sel_r      <= 2'd0;
      gnt_r      <= 4'b0000;
      busy_r     <= 1'b0;
      y_q_r      <= 1'b0;
      y_valid_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            state_r    <= ST_GRANT;
            gnt_r      <= onehot4(pick_idx_s);
            sel_r      <= pick_idx_s;
            busy_r     <= 1'b1;
            hold_cnt_r <= '0;
          end else begin
            gnt_r      <= 4'b0000;
            busy_r     <= 1'b0;
          end
        end
        ST_GRANT: begin
          y_q_r     <= data_in[sel_r];
          y_valid_r <= 1'b1;
          if (vol_s || lim_s) begin
            // sel keeps the owner index; a limit hit together with a
            // voluntary drop is reported as voluntary.
            state_r    <= ST_IDLE;
            gnt_r      <= 4'b0000;
            busy_r     <= 1'b0;
            last_r     <= sel_r;
            hold_cnt_r <= '0;
            timeout_r  <= lim_s & ~vol_s;
          end else begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt_r      <= 4'b0000;
          busy_r     <= 1'b0;
          hold_cnt_r <= '0;
        end
      endcase
    end
  end

  assign sel     = sel_r;
  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign y_q     = y_q_r;
  assign y_valid = y_valid_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Testbench for mux_4x1_rr_arbiter: two instances (MAX_HOLD=8 and 1) share
// stimulus; a behavioural model predicts each instance's outputs, and a
// monitor pops the predictions and compares them one cycle later.
module tb_mux_4x1_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y_q;
    logic       y_valid;
    logic       timeout;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data_in;

  logic [1:0] sel8, sel1;
  logic [3:0] gnt8, gnt1;
  logic       busy8, busy1, yq8, yq1, yv8, yv1, to8, to1;

  int vectors    = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Behavioural model state, index 0 = MAX_HOLD 8, index 1 = MAX_HOLD 1.
  int   m_owner[2];
  int   m_held[2];
  int   m_last[2];
  int   m_sel[2];
  logic m_yq[2];
  int   m_maxh[2];

  mux_4x1_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .sel(sel8), .gnt(gnt8), .busy(busy8), .y_q(yq8),
    .y_valid(yv8), .timeout(to8)
  );

  mux_4x1_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .sel(sel1), .gnt(gnt1), .busy(busy1), .y_q(yq1),
    .y_valid(yv1), .timeout(to1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_maxh[0] = 8;
    m_maxh[1] = 1;
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_held[m]  = 0;
      m_last[m]  = 3;
      m_sel[m]   = 0;
      m_yq[m]    = 1'b0;
    end
  endtask

  // Outputs expected after the next clock edge given inputs r, d.
  task automatic model_step(input int m, input logic [3:0] r,
                            input logic [3:0] d, output exp_t e);
    logic tmo;
    logic yv;
    int   idx;
    tmo = 1'b0;
    yv  = 1'b0;
    if (m_owner[m] < 0) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last[m] + k) % 4;
        if (m_owner[m] < 0 && r[idx]) begin
          m_owner[m] = idx;
          m_held[m]  = 1;
          m_sel[m]   = idx;
        end
      end
    end else begin
      yv      = 1'b1;
      m_yq[m] = d[m_owner[m]];
      if (!r[m_owner[m]] || m_held[m] == m_maxh[m]) begin
        tmo        = r[m_owner[m]];
        m_last[m]  = m_owner[m];
        m_owner[m] = -1;
      end else begin
        m_held[m] = m_held[m] + 1;
      end
    end
    e.gnt     = (m_owner[m] >= 0) ? (4'b0001 << m_owner[m]) : 4'b0000;
    e.sel     = 2'(m_sel[m]);
    e.busy    = (m_owner[m] >= 0);
    e.y_q     = m_yq[m];
    e.y_valid = yv;
    e.timeout = tmo;
  endtask

  task automatic check_vec(input string nm, input exp_t e, input exp_t a);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s t=%0t: got gnt=%b sel=%0d busy=%b y_q=%b y_valid=%b timeout=%b, expected gnt=%b sel=%0d busy=%b y_q=%b y_valid=%b timeout=%b",
               nm, $time, a.gnt, a.sel, a.busy, a.y_q, a.y_valid, a.timeout,
               e.gnt, e.sel, e.busy, e.y_q, e.y_valid, e.timeout);
    end
  endtask

  // Apply one cycle of stimulus and queue the predicted response.
  task automatic drive(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    req     = r;
    data_in = d;
    model_step(0, r, d, e);
    q0.push_back(e);
    model_step(1, r, d, e);
    q1.push_back(e);
  endtask

  // Monitor: compare registered outputs shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check_vec("mh8", q0.pop_front(), {gnt8, sel8, busy8, yq8, yv8, to8});
    if (q1.size() > 0) check_vec("mh1", q1.pop_front(), {gnt1, sel1, busy1, yq1, yv1, to1});
  end

  initial begin
    exp_t       zero;
    logic [3:0] r;
    zero    = '0;
    rst     = 1'b1;
    req     = 4'b0000;
    data_in = 4'b0000;
    model_reset();

    @(posedge clk);
    #1;
    check_vec("reset8", zero, {gnt8, sel8, busy8, yq8, yv8, to8});
    check_vec("reset1", zero, {gnt1, sel1, busy1, yq1, yv1, to1});
    #3;
    rst = 1'b0;

    // Single requester, capture, voluntary drop.
    drive(4'b0001, 4'b0001);
    drive(4'b0001, 4'b0001);
    drive(4'b0000, 4'b0001);
    drive(4'b0000, 4'b0000);

    // All requesting: rotation with forced releases.
    for (int i = 0; i < 40; i++) drive(4'b1111, 4'($urandom));
    drive(4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000);

    // Rotation after voluntary release, then lone requester.
    drive(4'b0001, 4'b1111);
    drive(4'b0001, 4'b1111);
    drive(4'b0000, 4'b1111);
    for (int i = 0; i < 4; i++) drive(4'b0101, 4'b0100);
    drive(4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) drive(4'b0001, 4'b0001);
    drive(4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000);

    // Data toggling under owner 1, then y_q holds after release.
    for (int i = 0; i < 6; i++) drive(4'b0010, (i % 2 == 0) ? 4'b1010 : 4'b0101);
    for (int i = 0; i < 3; i++) drive(4'b0000, 4'b1111);

    // Reset in the third grant cycle of owner 2.
    for (int i = 0; i < 10; i++) begin
      if (m_owner[0] == 2 && m_held[0] == 3) break;
      drive(4'b0100, 4'($urandom));
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_vec("midrst8", zero, {gnt8, sel8, busy8, yq8, yv8, to8});
    check_vec("midrst1", zero, {gnt1, sel1, busy1, yq1, yv1, to1});
    model_reset();
    @(posedge clk);
    #1;
    check_vec("rsthold8", zero, {gnt8, sel8, busy8, yq8, yv8, to8});
    check_vec("rsthold1", zero, {gnt1, sel1, busy1, yq1, yv1, to1});
    rst = 1'b0;
    for (int i = 0; i < 3; i++) drive(4'b0100, 4'b0100);
    drive(4'b0000, 4'b0000);
    drive(4'b0000, 4'b0000);

    // Constant single requester: alternation with timeout on MAX_HOLD=1.
    for (int i = 0; i < 8; i++) drive(4'b0010, 4'b0010);
    drive(4'b0000, 4'b0000);

    // Randomized traffic with occasionally held request patterns.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      drive(r, 4'($urandom));
    end
    drive(4'b0000, 4'b0000);

    @(posedge clk);
    #2;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d queued predictions, expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
